fetch_stage: RTL and testbench
==============================

// Module: fetch_stage
// PURPOSE
// - LC-3b IF stage: produces the instruction stream that the decode stage consumes.
// - Owns the PC and runs the instruction-memory read handshake (hold until resp).
// - Delivers {instruction, pc, pc+2} through a valid/stall IF/ID output register with a 1-entry buffer.
// - Handles branch/jump redirects from later stages, incl. squashing in-flight fetches.
// PARAMETERS
// RESET_PC  16'h0000  PC value loaded on reset
// PORTS
// clk              in   1   clock; all state on rising edge
// reset            in   1   synchronous, active-high reset
// imem_read        out  1   instruction read request; held until imem_resp
// imem_address     out  16  fetch address (= pc or held request address); stable while imem_read=1
// imem_resp        in   1   1-cycle pulse: imem_rdata valid
// imem_rdata       in   16  fetched instruction word
// stall            in   1   decode cannot accept this cycle
// redirect         in   1   branch/jump resolved taken; flush and refetch
// redirect_target  in   16  new PC (bit 0 ignored, forced to 0)
// if_valid         out  1   IF/ID register holds a live instruction
// if_instruction   out  16  instruction to decode
// if_pc            out  16  address of if_instruction
// if_pc_plus2      out  16  if_pc + 2 (mod 2^16)
// BEHAVIOUR
// - Reset: pc=RESET_PC, state=REQ, buffer empty, if_valid=0, if_instruction/if_pc/if_pc_plus2=0.
//   imem_read=0 while reset=1; memory shares reset, any in-flight request is abandoned.
// - imem_read = (state==REQ || state==DRAIN) && !reset; combinational from state.
// - Output reg "free" = !if_valid || !stall. Consume = if_valid && !stall.
// - States:
//   REQ:   imem_address=pc. On resp (no redirect): if free -> load output reg, pc+=2, stay REQ;
//          else -> capture into buffer, pc+=2, go HOLD. Redirect w/o resp -> latch target, go DRAIN.
//          Redirect with resp same cycle -> discard rdata, pc=target, stay REQ.
//   DRAIN: imem_address=held pc; imem_read=1 until resp. resp -> discard, pc=pending target, go REQ.
//          Further redirect in DRAIN overwrites pending target (latest wins); redirect+resp same
//          cycle -> use the new target.
//   HOLD:  imem_read=0. When free -> buffer moves to output reg, go REQ (next fetch at pc).
//          Redirect -> drop buffer, pc=target, go REQ.
// - Redirect has priority over stall and over resp: at the edge it is seen, if_valid<=0 and
//   no data from that cycle's resp reaches the output reg or buffer.
// - Latency: resp at edge N -> if_valid=1 after edge N (if free); next imem_read same cycle.
// - pc arithmetic 16-bit, wraps 16'hFFFE -> 16'h0000; if_pc_plus2 wraps identically.
// - Output reg holds value unchanged while if_valid && stall; never drops or duplicates.
// - Outputs if_* and buffer registered; no combinational path stall/redirect -> if_*.
// TESTING
// - Straight-line: reset, resp each 2nd cycle, rdata 16'h1234,16'h5678 -> if_pc 0,2; instr in order, pc_plus2 2,4.
// - Stall: stall=1 for 5 cycles with output full, one resp 16'hABCD -> HOLD, imem_read=0; on stall=0 ABCD follows, then fetch at pc+2.
// - In-flight redirect: redirect to 16'h0040 while REQ@0x0006 pending -> imem_address stays 0x0006 until resp, rdata discarded, next fetch 0x0040, if_valid=0 meanwhile.
// - Redirect+resp same cycle (target 16'h0100) -> rdata dropped, next imem_address=0x0100, no instruction from old path emitted.
// - Wrap: RESET_PC=16'hFFFE -> if_pc FFFE, pc_plus2 0000, next fetch 0x0000.
// - Reset mid-DRAIN and mid-HOLD -> next cycle if_valid=0, imem_read=1, imem_address=RESET_PC.

Source files
------------

// File: rtl/fetch_stage.sv
// LC-3b instruction fetch stage.
// Owns the PC, runs the instruction-memory read handshake, and presents
// {instruction, pc, pc+2} to decode through a valid/stall register backed
// by a single-entry buffer. Redirects flush the stage and squash any
// fetch that is still outstanding.
module fetch_stage #(
    parameter logic [15:0] RESET_PC = 16'h0000
) (
    input  logic        clk,
    input  logic        reset,
    output logic        imem_read,
    output logic [15:0] imem_address,
    input  logic        imem_resp,
    input  logic [15:0] imem_rdata,
    input  logic        stall,
    input  logic        redirect,
    input  logic [15:0] redirect_target,
    output logic        if_valid,
    output logic [15:0] if_instruction,
    output logic [15:0] if_pc,
    output logic [15:0] if_pc_plus2
);

    typedef enum logic [1:0] {
        S_REQ   = 2'd0,
        S_DRAIN = 2'd1,
        S_HOLD  = 2'd2
    } state_t;

    state_t      state;
    logic [15:0] pc;
    logic [15:0] pend_target;
    logic [15:0] hold_instr;
    logic [15:0] hold_pc;

    logic        out_free;
    logic        out_consume;
    logic [15:0] tgt;
    logic [15:0] pc_next;

    // Handshake and helper signals derived from current state
    always_comb begin
        out_free     = !if_valid || !stall;
        out_consume  = if_valid && !stall;
        tgt          = redirect_target & 16'hFFFE;
        pc_next      = pc + 16'd2;
        imem_read    = ((state == S_REQ) || (state == S_DRAIN)) && !reset;
        // pc is not advanced while a squashed fetch drains, so it is the held address
        imem_address = pc;
    end

    // Fetch FSM, PC, pending redirect target, skid buffer and IF/ID register
    always_ff @(posedge clk) begin
        if (reset) begin
            state          <= S_REQ;
            pc             <= RESET_PC;
            pend_target    <= '0;
            hold_instr     <= '0;
            hold_pc        <= '0;
            if_valid       <= 1'b0;
            if_instruction <= '0;
            if_pc          <= '0;
            if_pc_plus2    <= '0;
        end else begin
            case (state)
                S_REQ: begin
                    if (redirect) begin
                        if_valid <= 1'b0;
                        if (imem_resp) begin
                            pc <= tgt;
                        end else begin
                            pend_target <= tgt;
                            state       <= S_DRAIN;
                        end
                    end else if (imem_resp) begin
                        pc <= pc_next;
                        if (out_free) begin
                            if_valid       <= 1'b1;
                            if_instruction <= imem_rdata;
                            if_pc          <= pc;
                            if_pc_plus2    <= pc_next;
                        end else begin
                            hold_instr <= imem_rdata;
                            hold_pc    <= pc;
                            state      <= S_HOLD;
                        end
                    end else if (out_consume) begin
                        if_valid <= 1'b0;
                    end
                end
                S_DRAIN: begin
                    // Output was flushed on entry; nothing is loaded while draining
                    if_valid <= 1'b0;
                    if (redirect) begin
                        pend_target <= tgt;
                    end
                    if (imem_resp) begin
                        pc    <= redirect ? tgt : pend_target;
                        state <= S_REQ;
                    end
                end
                S_HOLD: begin
                    if (redirect) begin
                        if_valid <= 1'b0;
                        pc       <= tgt;
                        state    <= S_REQ;
                    end else if (out_free) begin
                        if_valid       <= 1'b1;
                        if_instruction <= hold_instr;
                        if_pc          <= hold_pc;
                        if_pc_plus2    <= hold_pc + 16'd2;
                        state          <= S_REQ;
                    end
                end
                default: begin
                    state <= S_REQ;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_stage.sv
// Directed testbench for fetch_stage. A second instance with RESET_PC=16'hFFFE
// shares the stimulus and is checked for PC wrap-around.
module tb_fetch_stage;

    logic        clk;
    logic        reset;
    logic        imem_resp;
    logic [15:0] imem_rdata;
    logic        stall;
    logic        redirect;
    logic [15:0] redirect_target;

    logic        a_read, b_read;
    logic [15:0] a_addr, b_addr;
    logic        a_valid, b_valid;
    logic [15:0] a_instr, b_instr;
    logic [15:0] a_pc, b_pc;
    logic [15:0] a_pc2, b_pc2;

    int unsigned total;
    int unsigned bad;

    fetch_stage dut (
        .clk             (clk),
        .reset           (reset),
        .imem_read       (a_read),
        .imem_address    (a_addr),
        .imem_resp       (imem_resp),
        .imem_rdata      (imem_rdata),
        .stall           (stall),
        .redirect        (redirect),
        .redirect_target (redirect_target),
        .if_valid        (a_valid),
        .if_instruction  (a_instr),
        .if_pc           (a_pc),
        .if_pc_plus2     (a_pc2)
    );

    fetch_stage #(.RESET_PC(16'hFFFE)) dut_wrap (
        .clk             (clk),
        .reset           (reset),
        .imem_read       (b_read),
        .imem_address    (b_addr),
        .imem_resp       (imem_resp),
        .imem_rdata      (imem_rdata),
        .stall           (stall),
        .redirect        (redirect),
        .redirect_target (redirect_target),
        .if_valid        (b_valid),
        .if_instruction  (b_instr),
        .if_pc           (b_pc),
        .if_pc_plus2     (b_pc2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Advance one clock; inputs change and outputs are sampled 1 time unit after the edge
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        total = 0;
        bad   = 0;
        reset = 1'b1;
        imem_resp = 1'b0;
        imem_rdata = '0;
        stall = 1'b0;
        redirect = 1'b0;
        redirect_target = '0;

        // Reset state
        step();
        step();
        chk("rst_read",  {31'd0, a_read},  32'd0);
        chk("rst_valid", {31'd0, a_valid}, 32'd0);
        chk("rst_instr", {16'd0, a_instr}, 32'd0);
        chk("rst_pc",    {16'd0, a_pc},    32'd0);
        chk("rst_pc2",   {16'd0, a_pc2},   32'd0);
        reset = 1'b0;
        #1;
        chk("rel_read", {31'd0, a_read}, 32'd1);
        chk("rel_addr", {16'd0, a_addr}, 32'h0000);

        // Straight-line: responses every second cycle
        step();
        chk("sl_addr0_held", {16'd0, a_addr}, 32'h0000);
        imem_resp = 1'b1; imem_rdata = 16'h1234;
        step();
        imem_resp = 1'b0;
        chk("sl1_valid", {31'd0, a_valid}, 32'd1);
        chk("sl1_instr", {16'd0, a_instr}, 32'h1234);
        chk("sl1_pc",    {16'd0, a_pc},    32'h0000);
        chk("sl1_pc2",   {16'd0, a_pc2},   32'h0002);
        chk("sl1_addr",  {16'd0, a_addr},  32'h0002);
        chk("sl1_read",  {31'd0, a_read},  32'd1);
        chk("wrap_pc",   {16'd0, b_pc},    32'hFFFE);
        chk("wrap_pc2",  {16'd0, b_pc2},   32'h0000);
        chk("wrap_addr", {16'd0, b_addr},  32'h0000);
        step();
        chk("sl_gap_valid", {31'd0, a_valid}, 32'd0);
        imem_resp = 1'b1; imem_rdata = 16'h5678;
        step();
        imem_resp = 1'b0;
        chk("sl2_valid", {31'd0, a_valid}, 32'd1);
        chk("sl2_instr", {16'd0, a_instr}, 32'h5678);
        chk("sl2_pc",    {16'd0, a_pc},    32'h0002);
        chk("sl2_pc2",   {16'd0, a_pc2},   32'h0004);
        chk("sl2_addr",  {16'd0, a_addr},  32'h0004);

        // Stall with output full; one response goes to the buffer
        stall = 1'b1;
        step();
        chk("st_hold_instr", {16'd0, a_instr}, 32'h5678);
        imem_resp = 1'b1; imem_rdata = 16'hABCD;
        step();
        imem_resp = 1'b0;
        chk("st_hold_read",  {31'd0, a_read},  32'd0);
        chk("st_hold_instr2", {16'd0, a_instr}, 32'h5678);
        for (int i = 0; i < 3; i++) begin
            step();
            chk("st_hold_pc",   {16'd0, a_pc},    32'h0002);
            chk("st_hold_read", {31'd0, a_read},  32'd0);
        end
        stall = 1'b0;
        step();
        chk("st_rel_valid", {31'd0, a_valid}, 32'd1);
        chk("st_rel_instr", {16'd0, a_instr}, 32'hABCD);
        chk("st_rel_pc",    {16'd0, a_pc},    32'h0004);
        chk("st_rel_pc2",   {16'd0, a_pc2},   32'h0006);
        chk("st_rel_read",  {31'd0, a_read},  32'd1);
        chk("st_rel_addr",  {16'd0, a_addr},  32'h0006);

        // Redirect while the fetch at 0x0006 is outstanding
        redirect = 1'b1; redirect_target = 16'h0040;
        step();
        redirect = 1'b0;
        chk("dr_valid", {31'd0, a_valid}, 32'd0);
        chk("dr_read",  {31'd0, a_read},  32'd1);
        chk("dr_addr",  {16'd0, a_addr},  32'h0006);
        step();
        chk("dr_addr2", {16'd0, a_addr}, 32'h0006);
        imem_resp = 1'b1; imem_rdata = 16'hDEAD;
        step();
        imem_resp = 1'b0;
        chk("dr_done_valid", {31'd0, a_valid}, 32'd0);
        chk("dr_done_addr",  {16'd0, a_addr},  32'h0040);
        chk("dr_done_read",  {31'd0, a_read},  32'd1);

        // Redirect coincident with a response; odd target bit 0 is cleared
        imem_resp = 1'b1; imem_rdata = 16'hBEEF;
        redirect = 1'b1; redirect_target = 16'h0101;
        step();
        imem_resp = 1'b0; redirect = 1'b0;
        chk("rr_valid", {31'd0, a_valid}, 32'd0);
        chk("rr_addr",  {16'd0, a_addr},  32'h0100);
        imem_resp = 1'b1; imem_rdata = 16'h1111;
        step();
        imem_resp = 1'b0;
        chk("rr_new_instr", {16'd0, a_instr}, 32'h1111);
        chk("rr_new_pc",    {16'd0, a_pc},    32'h0100);
        chk("rr_new_pc2",   {16'd0, a_pc2},   32'h0102);

        // Reset while draining
        redirect = 1'b1; redirect_target = 16'h0200;
        step();
        redirect = 1'b0;
        chk("rd_drain_addr", {16'd0, a_addr}, 32'h0102);
        reset = 1'b1;
        #1;
        chk("rd_read_in_reset", {31'd0, a_read}, 32'd0);
        step();
        reset = 1'b0;
        #1;
        chk("rd_valid", {31'd0, a_valid}, 32'd0);
        chk("rd_read",  {31'd0, a_read},  32'd1);
        chk("rd_addr",  {16'd0, a_addr},  32'h0000);

        // Reset while holding a buffered instruction
        stall = 1'b1;
        imem_resp = 1'b1; imem_rdata = 16'h2222;
        step();
        imem_rdata = 16'h3333;
        step();
        imem_resp = 1'b0;
        chk("rh_hold_read",  {31'd0, a_read},  32'd0);
        chk("rh_hold_instr", {16'd0, a_instr}, 32'h2222);
        reset = 1'b1;
        step();
        reset = 1'b0; stall = 1'b0;
        #1;
        chk("rh_valid", {31'd0, a_valid}, 32'd0);
        chk("rh_read",  {31'd0, a_read},  32'd1);
        chk("rh_addr",  {16'd0, a_addr},  32'h0000);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
